spie_arb: RTL and testbench
===========================

Name: spie_arb

Overview:
- Two-client arbiter that shares one SPI device (the spie internal register interface) between the CPU and a secondary bus master, such as a logger or SD block engine.
- Ownership is implicit: a client acquires the device by writing a non-zero chip select to the control register, and releases it by writing chip select zero.
- A watchdog evicts an owner that stays silent too long: it probes device readiness, then forces chip select off.
- Sits between the two client bus ports and the spie instance.

Parameters:
- clock_freq, 50_000_000, clk frequency in Hz.
- timeout_ms, 100, owner inactivity limit in ms; 0 disables eviction.
- TIMEOUT_CYCLES (localparam) = clock_freq/1000*timeout_ms; counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- c0_stb, c0_we, c0_addr  in  1 each  client 0 (CPU, tie-break priority after reset) strobe, write, address (0 = data, 1 = ctrl/status)
- c0_data_in  in  32  client 0 write data
- c0_data_out  out  32  client 0 read data
- c0_ack  out  1  client 0 ack
- c1_stb, c1_we, c1_addr, c1_data_in, c1_data_out, c1_ack  same as client 0, for client 1
- m_stb, m_we, m_addr  out  1 each  to spie
- m_data_out  out  32  write data to spie
- m_data_in  in  32  read data from spie
- m_ack  in  1  spie ack (always equals m_stb; unused except in assertions)

Behaviour:
- Acks: cN_ack = cN_stb, combinational, in every state. Clients never stall.
- States: IDLE, OWN, PROBE, RELEASE. Registers: owner (1 bit), last_grant (1 bit), tcnt, evicted[1:0] (sticky).
- Reset values: state = IDLE, last_grant = 1 (so client 0 wins the first tie), tcnt = 0, evicted = 0. m_stb and all data outputs are 0 in reset/IDLE when nothing is forwarded.
- Acquire request: client write with addr = 1 and data_in[2:0] != 0.

IDLE:
- An acquire request is forwarded to spie the same cycle (m_* = client signals). Next state is OWN, owner = that client, last_grant = owner, tcnt = 0, evicted[owner] = 0.
- Simultaneous acquires: the client != last_grant wins. The loser's write is dropped (acked, no effect).
- All other client accesses in IDLE: writes dropped; reads return 0.

OWN:
- All owner accesses are forwarded combinationally, zero added latency.
- Owner data reads return m_data_in.
- Owner ctrl reads return m_data_in with bit[1] forced to 1.
- Owner ctrl write with data_in[2:0] == 0: forwarded; next state IDLE.
- Non-owner: writes dropped; ctrl reads return {29'b0, evicted[n], 2'b00}; data reads return 0.
- tcnt clears on any owner access, otherwise increments.
- When tcnt == TIMEOUT_CYCLES - 1 and timeout_ms != 0, next state is PROBE. If an owner access occurs in that same cycle, the access wins: it is forwarded, tcnt clears, and no probe follows.

PROBE:
- Arbiter drives m_stb = 1, m_we = 0, m_addr = 1 for one cycle.
- If m_data_in[0] (spi ready) = 1, next state RELEASE; else stay in PROBE (re-probe every cycle).

RELEASE:
- Arbiter drives m_stb = 1, m_we = 1, m_addr = 1, m_data_out = 0 for one cycle.
- Sets evicted[owner] = 1; next state IDLE.

PROBE and RELEASE:
- All client accesses are acked with no effect; reads return 0, including the former owner's.

Reset mid-transfer:
- The arbiter returns to IDLE. spie shares rst, so no chip-select cleanup is needed.

Decomposition:
- Shared header spie_defs.vh: ctrl bit positions (CS[2:0], FAST 3, WIDTH[5:4], MSB 6), status bits (RDY 0, OWNED 1, EVICTED 2), SPI register addresses (DATA 0, CTRL 1), FSM state encodings.
- One sub-module, spie_arb_timer: inactivity counter with clear, enable and expired outputs. The FSM stays in spie_arb.

Test Plan:
- Client 0 writes ctrl 0x01, then data 0xA5 -> m_stb pulses for each write, same cycle; c0 status read shows bit1 = 1; after the transfer, c0 data read returns the spie rx byte.
- Both clients write ctrl 0x01 in the same cycle just after reset -> client 0 owns, client 1 status reads 0x0. After client 0 writes ctrl 0, repeat the tie -> client 1 wins.
- Client 1 data write 0x55 while client 0 owns -> c1_ack = 1, m_stb = 0, no transfer occurs.
- timeout_ms = 1 at clock_freq = 1_000_000, client 0 acquires then goes silent -> at 1000 idle cycles, PROBE read issued, then ctrl write 0 (cs_n = 3'b111); client 0 status read = 0x4; a new acquire clears bit2.
- Eviction during an active 32-bit transfer -> PROBE repeats until rdy = 1, and RELEASE occurs only after transfer completion.
- Assert rst while client 1 owns, mid-PROBE -> next cycle state = IDLE, m_stb = 0, client 0 acquires immediately.

Source files
------------

// File: rtl/spie_arb_pkg.sv
// Shared definitions for the spie two-client arbiter: FSM states, spie
// register map bit positions, the client request bundle and small decode
// helpers used by both the arbiter and anything that talks to it.
package spie_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_PROBE   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // spie register addresses
  localparam logic ADDR_CTRL = 1'b1;

  // ctrl register: chip select field
  localparam int CTRL_CS_LSB = 0;
  localparam int CTRL_CS_MSB = 2;

  // status register bits
  localparam int STAT_RDY     = 0;
  localparam int STAT_OWNED   = 1;
  localparam int STAT_EVICTED = 2;

  typedef struct packed {
    logic        stb;
    logic        we;
    logic        addr;
    logic [31:0] dat;
  } cli_req_t;

  function automatic logic is_ctrl_write(input cli_req_t r);
    return r.stb & r.we & (r.addr == ADDR_CTRL);
  endfunction

  function automatic logic cs_nonzero(input logic [31:0] ctrl);
    return |ctrl[CTRL_CS_MSB:CTRL_CS_LSB];
  endfunction

endpackage

// File: rtl/spie_arb_timer.sv
// Owner inactivity counter: clears on clr, counts while en, and flags the
// last cycle before the limit. A LIMIT of 0 means the watchdog never fires.
module spie_arb_timer #(
  parameter int unsigned LIMIT = 1000,
  parameter int          W     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [W-1:0] tcnt_q, tcnt_d;

  // clear has priority over counting so an access on the limit cycle restarts the window
  always_comb begin
    tcnt_d = tcnt_q;
    if (clr) begin
      tcnt_d = '0;
    end else if (en) begin
      tcnt_d = tcnt_q + W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign expired = (LIMIT != 0) && (tcnt_q == LAST);

endmodule

// File: rtl/spie_arb.sv
// Shares one spie instance between two bus clients. Ownership follows the
// chip-select writes; a watchdog evicts a silent owner by probing ready and
// then forcing chip select off. Clients are acked combinationally, never stalled.
module spie_arb
  import spie_arb_pkg::*;
#(
  parameter int unsigned clock_freq = 50_000_000,
  parameter int unsigned timeout_ms = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_stb,
  input  logic        c0_we,
  input  logic        c0_addr,
  input  logic [31:0] c0_data_in,
  output logic [31:0] c0_data_out,
  output logic        c0_ack,
  input  logic        c1_stb,
  input  logic        c1_we,
  input  logic        c1_addr,
  input  logic [31:0] c1_data_in,
  output logic [31:0] c1_data_out,
  output logic        c1_ack,
  output logic        m_stb,
  output logic        m_we,
  output logic        m_addr,
  output logic [31:0] m_data_out,
  input  logic [31:0] m_data_in,
  input  logic        m_ack
);

  localparam int unsigned TIMEOUT_CYCLES = clock_freq / 1000 * timeout_ms;
  localparam int TCNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] evicted_q, evicted_d;

  cli_req_t req0, req1, own_req, oth_req;
  logic     acq0, acq1, grant, own_rel;
  logic     tmr_clr, tmr_en, tmr_expired;
  logic [31:0] own_rdat, oth_rdat;

  assign req0 = {c0_stb, c0_we, c0_addr, c0_data_in};
  assign req1 = {c1_stb, c1_we, c1_addr, c1_data_in};

  assign c0_ack = c0_stb;
  assign c1_ack = c1_stb;

  // acquire decode and round-robin tie-break: the client not granted last time wins
  assign acq0  = is_ctrl_write(req0) & cs_nonzero(req0.dat);
  assign acq1  = is_ctrl_write(req1) & cs_nonzero(req1.dat);
  assign grant = (acq0 & acq1) ? ~last_grant_q : acq1;

  assign own_req = owner_q ? req1 : req0;
  assign oth_req = owner_q ? req0 : req1;
  assign own_rel = is_ctrl_write(own_req) & ~cs_nonzero(own_req.dat);

  spie_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TCNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      evicted_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      evicted_q    <= evicted_d;
    end
  end

  // next-state: ownership hand-over, watchdog and eviction bookkeeping
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    evicted_d    = evicted_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acq0 | acq1) begin
          state_d            = ST_OWN;
          owner_d            = grant;
          last_grant_d       = grant;
          evicted_d[grant]   = 1'b0;
          tmr_clr            = 1'b1;
        end
      end
      ST_OWN: begin
        tmr_en  = 1'b1;
        tmr_clr = own_req.stb;
        if (own_rel) begin
          state_d = ST_IDLE;
        end else if (!own_req.stb && tmr_expired) begin
          state_d = ST_PROBE;
        end
      end
      ST_PROBE: begin
        // keep polling until the in-flight transfer has drained
        if (m_data_in[STAT_RDY]) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        evicted_d[owner_q] = 1'b1;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs: forward the owner, synthesize probe/release cycles, steer read data
  always_comb begin
    m_stb      = 1'b0;
    m_we       = 1'b0;
    m_addr     = 1'b0;
    m_data_out = '0;
    own_rdat   = '0;
    oth_rdat   = '0;
    case (state_q)
      ST_IDLE: begin
        if (acq0 | acq1) begin
          m_stb      = 1'b1;
          m_we       = 1'b1;
          m_addr     = ADDR_CTRL;
          m_data_out = grant ? c1_data_in : c0_data_in;
        end
      end
      ST_OWN: begin
        if (own_req.stb) begin
          m_stb      = 1'b1;
          m_we       = own_req.we;
          m_addr     = own_req.addr;
          m_data_out = own_req.dat;
          if (!own_req.we) begin
            own_rdat = m_data_in;
            if (own_req.addr == ADDR_CTRL) begin
              own_rdat[STAT_OWNED] = 1'b1;
            end
          end
        end
        if (oth_req.stb && !oth_req.we && (oth_req.addr == ADDR_CTRL)) begin
          oth_rdat[STAT_EVICTED] = evicted_q[~owner_q];
        end
      end
      ST_PROBE: begin
        m_stb  = 1'b1;
        m_addr = ADDR_CTRL;
      end
      ST_RELEASE: begin
        m_stb  = 1'b1;
        m_we   = 1'b1;
        m_addr = ADDR_CTRL;
      end
      default: ;
    endcase
    c0_data_out = owner_q ? oth_rdat : own_rdat;
    c1_data_out = owner_q ? own_rdat : oth_rdat;
  end

  // spie acks in the same cycle it is strobed
  ack_follows_stb: assert property (@(posedge clk) disable iff (rst) m_ack == m_stb);

endmodule

// File: tb/tb_spie_arb.sv
// Bench for spie_arb: directed steps for the ownership, tie-break, watchdog and
// reset scenarios, then random traffic; every cycle is checked against a
// transaction-level model of who owns the device and what each client sees.
module tb_spie_arb;

  localparam int unsigned CF  = 1_000_000;
  localparam int unsigned TMS = 1;
  localparam int          T   = 1000;

  localparam int M_IDLE = 0, M_OWN = 1, M_PROBE = 2, M_RELEASE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c0_stb = 0, c0_we = 0, c0_addr = 0;
  logic [31:0] c0_data_in = '0;
  logic [31:0] c0_data_out;
  logic        c0_ack;
  logic        c1_stb = 0, c1_we = 0, c1_addr = 0;
  logic [31:0] c1_data_in = '0;
  logic [31:0] c1_data_out;
  logic        c1_ack;
  logic        m_stb, m_we, m_addr;
  logic [31:0] m_data_out;
  logic [31:0] m_data_in = '0;
  logic        m_ack;

  int checks = 0;
  int fails  = 0;

  // model of the arbiter as seen from outside
  int       md_mode;
  bit       md_owner;
  bit       md_last;
  int       md_idle;
  bit [1:0] md_ev;

  always #5 clk = ~clk;
  assign m_ack = m_stb;

  spie_arb #(.clock_freq(CF), .timeout_ms(TMS)) dut (
    .clk(clk), .rst(rst),
    .c0_stb(c0_stb), .c0_we(c0_we), .c0_addr(c0_addr), .c0_data_in(c0_data_in),
    .c0_data_out(c0_data_out), .c0_ack(c0_ack),
    .c1_stb(c1_stb), .c1_we(c1_we), .c1_addr(c1_addr), .c1_data_in(c1_data_in),
    .c1_data_out(c1_data_out), .c1_ack(c1_ack),
    .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_data_out(m_data_out),
    .m_data_in(m_data_in), .m_ack(m_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_mode  = M_IDLE;
    md_owner = 1'b0;
    md_last  = 1'b1;
    md_idle  = 0;
    md_ev    = 2'b00;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    c0_stb = 0; c0_we = 0; c0_addr = 0; c0_data_in = '0;
    c1_stb = 0; c1_we = 0; c1_addr = 0; c1_data_in = '0;
    m_data_in = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // one bus cycle: drive, compare against the model, advance the model
  task automatic step(input logic s0, input logic w0, input logic a0, input logic [31:0] d0,
                      input logic s1, input logic w1, input logic a1, input logic [31:0] d1,
                      input logic [31:0] mi);
    logic        s[2], w[2], a[2], acq[2];
    logic [31:0] d[2], er[2];
    logic        e_stb, e_we, e_addr;
    logic [31:0] e_mdo;
    int          o, n, g;
    @(negedge clk);
    c0_stb = s0; c0_we = w0; c0_addr = a0; c0_data_in = d0;
    c1_stb = s1; c1_we = w1; c1_addr = a1; c1_data_in = d1;
    m_data_in = mi;
    #2;
    s[0] = s0; w[0] = w0; a[0] = a0; d[0] = d0;
    s[1] = s1; w[1] = w1; a[1] = a1; d[1] = d1;
    for (int i = 0; i < 2; i++) acq[i] = s[i] && w[i] && a[i] && (d[i][2:0] != 3'b000);
    e_stb = 0; e_we = 0; e_addr = 0; e_mdo = '0; er[0] = '0; er[1] = '0;
    o = int'(md_owner);
    n = 1 - o;
    case (md_mode)
      M_IDLE: begin
        if (acq[0] || acq[1]) begin
          g = (acq[0] && acq[1]) ? int'(!md_last) : (acq[1] ? 1 : 0);
          e_stb = 1; e_we = 1; e_addr = 1; e_mdo = d[g];
          md_mode = M_OWN; md_owner = g[0]; md_last = g[0]; md_idle = 0; md_ev[g] = 1'b0;
        end
      end
      M_OWN: begin
        if (s[o]) begin
          e_stb = 1; e_we = w[o]; e_addr = a[o]; e_mdo = d[o];
          if (!w[o]) er[o] = a[o] ? (mi | 32'h2) : mi;
        end
        if (s[n] && !w[n] && a[n]) er[n] = md_ev[n] ? 32'h4 : 32'h0;
        if (s[o] && w[o] && a[o] && d[o][2:0] == 3'b000) md_mode = M_IDLE;
        else if (s[o]) md_idle = 0;
        else if (md_idle == T - 1) md_mode = M_PROBE;
        else md_idle++;
      end
      M_PROBE: begin
        e_stb = 1; e_addr = 1;
        if (mi[0]) md_mode = M_RELEASE;
      end
      default: begin
        e_stb = 1; e_we = 1; e_addr = 1;
        md_ev[o] = 1'b1;
        md_mode = M_IDLE;
      end
    endcase
    chk("c0_ack", {31'b0, c0_ack}, {31'b0, s0});
    chk("c1_ack", {31'b0, c1_ack}, {31'b0, s1});
    chk("m_stb", {31'b0, m_stb}, {31'b0, e_stb});
    chk("m_we", {31'b0, m_we}, {31'b0, e_we});
    chk("m_addr", {31'b0, m_addr}, {31'b0, e_addr});
    chk("m_data_out", m_data_out, e_mdo);
    if (s0 && !w0) chk("c0_rdat", c0_data_out, er[0]);
    if (s1 && !w1) chk("c1_rdat", c1_data_out, er[1]);
  endtask

  // shorthand single-client cycles
  task automatic acc(input int c, input logic w, input logic a, input logic [31:0] dt,
                     input logic [31:0] mi);
    if (c == 0) step(1, w, a, dt, 0, 0, 0, '0, mi);
    else        step(0, 0, 0, '0, 1, w, a, dt, mi);
  endtask

  task automatic quiet(input int k, input logic [31:0] mi);
    for (int i = 0; i < k; i++) step(0, 0, 0, '0, 0, 0, 0, '0, mi);
  endtask

  initial begin
    logic        rs0, rw0, ra0, rs1, rw1, ra1;
    logic [31:0] rd0, rd1;
    model_reset();
    do_reset(3);

    // reset state: nothing forwarded
    quiet(1, 32'hFFFF_FFFF);
    chk("rst_m_stb", {31'b0, m_stb}, 32'h0);

    // client 0 acquires, writes data, reads status and rx byte
    acc(0, 1, 1, 32'h01, 32'h0);
    chk("acq_fwd", m_data_out, 32'h01);
    acc(0, 1, 0, 32'hA5, 32'h0);
    chk("data_fwd", m_data_out, 32'hA5);
    acc(0, 0, 1, '0, 32'h1);
    chk("own_status", c0_data_out, 32'h3);
    acc(0, 0, 0, '0, 32'h5A);
    chk("own_rx", c0_data_out, 32'h5A);
    // non-owner write dropped, non-owner status read
    acc(1, 1, 0, 32'h55, 32'h0);
    chk("nonown_wr_stb", {31'b0, m_stb}, 32'h0);
    acc(1, 0, 1, '0, 32'hFFFF_FFFF);
    chk("nonown_status", c1_data_out, 32'h0);
    acc(0, 1, 1, 32'h0, 32'h0);

    // tie straight after reset: client 0 wins; then the tie flips to client 1
    do_reset(2);
    step(1, 1, 1, 32'h01, 1, 1, 1, 32'h03, 32'h0);
    chk("tie1_winner", m_data_out, 32'h01);
    acc(1, 0, 1, '0, 32'hFFFF_FFFF);
    chk("tie1_loser_status", c1_data_out, 32'h0);
    acc(0, 1, 1, 32'h0, 32'h0);
    step(1, 1, 1, 32'h01, 1, 1, 1, 32'h03, 32'h0);
    chk("tie2_winner", m_data_out, 32'h03);
    acc(1, 1, 1, 32'h0, 32'h0);

    // watchdog: access on the limit cycle wins, then silence leads to eviction
    acc(0, 1, 1, 32'h01, 32'h0);
    quiet(T - 1, 32'h0);
    acc(0, 0, 0, '0, 32'h0);
    quiet(T, 32'h0);
    for (int i = 0; i < 3; i++) begin
      quiet(1, 32'h0);
      chk("probe_busy", {29'b0, m_stb, m_we, m_addr}, 32'h5);
    end
    quiet(1, 32'h1);
    quiet(1, 32'h0);
    chk("release_wr", {29'b0, m_stb, m_we, m_addr}, 32'h7);
    acc(1, 1, 1, 32'h01, 32'h0);
    acc(0, 0, 1, '0, 32'h0);
    chk("evicted_status", c0_data_out, 32'h4);
    acc(1, 1, 1, 32'h0, 32'h0);
    acc(0, 1, 1, 32'h02, 32'h0);
    acc(0, 1, 1, 32'h0, 32'h0);
    acc(1, 1, 1, 32'h01, 32'h0);
    acc(0, 0, 1, '0, 32'h0);
    chk("evicted_cleared", c0_data_out, 32'h0);
    acc(1, 1, 1, 32'h0, 32'h0);

    // reset while client 1 owns and the probe is still waiting on ready
    acc(1, 1, 1, 32'h01, 32'h0);
    quiet(T + 2, 32'h0);
    do_reset(1);
    acc(0, 1, 1, 32'h01, 32'h0);
    chk("post_rst_acq", m_data_out, 32'h01);
    acc(0, 1, 1, 32'h0, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rs0 = 1'($urandom_range(0, 1)); rw0 = 1'($urandom_range(0, 1)); ra0 = 1'($urandom_range(0, 1));
      rs1 = 1'($urandom_range(0, 1)); rw1 = 1'($urandom_range(0, 1)); ra1 = 1'($urandom_range(0, 1));
      rd0 = $urandom; rd1 = $urandom;
      if ($urandom_range(0, 3) == 0) rd0[2:0] = 3'b000;
      if ($urandom_range(0, 3) == 0) rd1[2:0] = 3'b000;
      step(rs0, rw0, ra0, rd0, rs1, rw1, ra1, rd1, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
